imem_fetch_sequencer: RTL and testbench

Sequences the instruction memory: owns its 10-bit address port, selects one of four program entry points, steps the PC and delivers registered instructions to decode.
Applies branch/jump redirects with a one-cycle flush, honours stalls and halts, and faults on out-of-range PCs.
Shares the memory read port with a debug/inspection requester while the core is not running.

---
 rtl/imem_fetch_sequencer.sv | 110 +++++++++++
 tb/tb_imem_fetch_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_sequencer.sv
// Instruction-memory fetch sequencer: owns the memory address port, steps the PC,
// registers instructions for decode, and lends the read port to debug when idle.
module imem_fetch_sequencer #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int PROG0_BASE = 0,
  parameter int PROG1_BASE = 10,
  parameter int PROG2_BASE = 21,
  parameter int PROG3_BASE = 0,
  parameter int MAX_ADDR   = 80
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        prog_sel,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  output logic              busy,
  output logic              fault,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // A full address space lets pc+1 wrap instead of faulting.
  localparam bit WRAP_OK = (MAX_ADDR == (2 ** ADDR_W) - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W:0]   seq_ext;
  logic              run;
  logic              range_bad;

  assign run = (state == ST_RUN);
  assign busy = run;

  always_comb begin
    base = ADDR_W'(PROG0_BASE);
    case (prog_sel)
      2'd1:    base = ADDR_W'(PROG1_BASE);
      2'd2:    base = ADDR_W'(PROG2_BASE);
      2'd3:    base = ADDR_W'(PROG3_BASE);
      default: base = ADDR_W'(PROG0_BASE);
    endcase
  end

  assign seq_ext   = {1'b0, pc} + (ADDR_W+1)'(1);
  assign next_pc   = redirect_valid ? redirect_addr : seq_ext[ADDR_W-1:0];
  assign range_bad = redirect_valid ? (redirect_addr > ADDR_W'(MAX_ADDR))
                                    : (!WRAP_OK && (seq_ext > (ADDR_W+1)'(MAX_ADDR)));

  // start takes precedence over a debug request so the first fetch sees the base PC.
  assign dbg_gnt     = dbg_req && !run && !start;
  assign mem_address = dbg_gnt ? dbg_addr : pc;
  assign dbg_rdata   = dbg_gnt ? mem_rdata : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt_req) begin
            state       <= ST_HALTED;
            instr_valid <= 1'b0;
          end else if (!stall) begin
            // Word fetched alongside a redirect is wrong-path: load it but mark invalid.
            instr_out   <= mem_rdata;
            pc_out      <= pc;
            instr_valid <= !redirect_valid;
            if (range_bad) begin
              fault <= 1'b1;
              state <= ST_HALTED;
            end else begin
              pc <= next_pc;
            end
          end
        end
        default: begin
          instr_valid <= 1'b0;
          if (start) begin
            pc    <= base;
            fault <= 1'b0;
            state <= ST_RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Self-checking bench for imem_fetch_sequencer: directed scenarios plus a randomized
// run, all checked against a behavioural model of the fetch rules.
module tb_imem_fetch_sequencer;
  localparam int MAXA = 80;

  logic        clock = 0, reset = 1, start = 0, stall = 0, redirect_valid = 0, halt_req = 0, dbg_req = 0;
  logic [1:0]  prog_sel = 0;
  logic [9:0]  redirect_addr = 0, dbg_addr = 0, mem_address, pc_out;
  logic [31:0] mem_rdata, instr_out, dbg_rdata;
  logic        instr_valid, busy, fault, dbg_gnt;
  logic [31:0] ram [0:1023];

  int total = 0, bad = 0;

  // model: 0 idle, 1 running, 2 halted
  int          m_state;
  logic [9:0]  m_pc, m_pcout;
  logic [31:0] m_instr;
  logic        m_valid, m_fault;

  imem_fetch_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .prog_sel(prog_sel), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halt_req(halt_req),
    .mem_address(mem_address), .mem_rdata(mem_rdata), .instr_out(instr_out), .pc_out(pc_out),
    .instr_valid(instr_valid), .busy(busy), .fault(fault), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata)
  );

  assign mem_rdata = ram[mem_address];
  always #5 clock = ~clock;

  function automatic logic [9:0] base_of(input logic [1:0] s);
    case (s)
      2'd1: return 10'd10;
      2'd2: return 10'd21;
      default: return 10'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_pcout = 0; m_instr = 0; m_valid = 0; m_fault = 0;
  endtask

  // One clock of the architectural rules, applied to the inputs currently driven.
  task automatic model_edge();
    int nxt;
    if (m_state != 1) begin
      m_valid = 0;
      if (start) begin m_pc = base_of(prog_sel); m_fault = 0; m_state = 1; end
    end else if (halt_req) begin
      m_state = 2; m_valid = 0;
    end else if (!stall) begin
      nxt = redirect_valid ? int'(redirect_addr) : int'(m_pc) + 1;
      m_instr = ram[m_pc]; m_pcout = m_pc; m_valid = !redirect_valid;
      if (nxt > MAXA) begin m_fault = 1; m_state = 2; end
      else m_pc = 10'(nxt);
    end
  endtask

  task automatic tick();
    #1; model_edge(); @(posedge clock); #1;
  endtask

  task automatic begin_prog(input logic [1:0] s);
    halt_req = 1; tick(); halt_req = 0;
    prog_sel = s; start = 1; tick(); start = 0;
  endtask

  task automatic test_reset();
    reset = 1; model_reset(); #12; reset = 0; @(posedge clock); #1;
    total++;
    if ({instr_out, pc_out, instr_valid, busy, fault} !== 45'd0) begin
      bad++; $display("FAIL reset_state: got instr=%h pc=%0d v=%b busy=%b fault=%b want all zero", instr_out, pc_out, instr_valid, busy, fault);
    end
    prog_sel = 0; start = 1; tick(); start = 0;
    for (int i = 0; i < 20 && m_pc != 7; i++) tick();
    #1; reset = 1; #1;
    total++;
    if ({instr_out, pc_out, instr_valid, busy, fault} !== 45'd0) begin
      bad++; $display("FAIL async_reset: got instr=%h pc=%0d v=%b busy=%b fault=%b want all zero", instr_out, pc_out, instr_valid, busy, fault);
    end
    model_reset(); #1; reset = 0;
    prog_sel = 1; start = 1; tick(); start = 0;
    total++;
    if (mem_address !== 10'd10) begin bad++; $display("FAIL prog1_addr: got %0d want 10", mem_address); end
    tick();
    total++;
    if ({instr_out, pc_out, instr_valid} !== {ram[10], 10'd10, 1'b1}) begin
      bad++; $display("FAIL prog1_first: got instr=%h pc=%0d v=%b want instr=%h pc=10 v=1", instr_out, pc_out, instr_valid, ram[10]);
    end
  endtask

  task automatic test_sequence();
    begin_prog(0);
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({pc_out, instr_valid, instr_out} !== {10'(i), 1'b1, ram[i]}) begin
        bad++; $display("FAIL seq_%0d: got pc=%0d v=%b instr=%h want pc=%0d v=1 instr=%h", i, pc_out, instr_valid, instr_out, i, ram[i]);
      end
    end
    redirect_valid = 1; redirect_addr = 5; tick(); redirect_valid = 0;
    total++;
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL redirect_bubble: got v=%b want 0", instr_valid); end
    tick();
    total++;
    if ({pc_out, instr_valid, instr_out} !== {10'd5, 1'b1, ram[5]}) begin
      bad++; $display("FAIL redirect_target: got pc=%0d v=%b want pc=5 v=1", pc_out, instr_valid);
    end
  endtask

  task automatic test_stall();
    begin_prog(0);
    for (int i = 0; i < 4; i++) tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({pc_out, instr_out, instr_valid} !== {10'd3, ram[3], 1'b1}) begin
        bad++; $display("FAIL stall_hold_%0d: got pc=%0d instr=%h v=%b want pc=3 instr=%h v=1", i, pc_out, instr_out, instr_valid, ram[3]);
      end
    end
    stall = 0; tick();
    total++;
    if ({pc_out, instr_out, instr_valid} !== {10'd4, ram[4], 1'b1}) begin
      bad++; $display("FAIL stall_release: got pc=%0d v=%b want pc=4 v=1", pc_out, instr_valid);
    end
  endtask

  task automatic test_stall_redirect();
    logic [9:0] held_pc;
    begin_prog(0); tick(); tick();
    redirect_valid = 1; redirect_addr = 40; stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({pc_out, instr_valid} !== {10'd1, 1'b1}) begin
        bad++; $display("FAIL stall_beats_redirect_%0d: got pc=%0d v=%b want pc=1 v=1", i, pc_out, instr_valid);
      end
    end
    stall = 0; tick(); redirect_valid = 0;
    total++;
    if ({pc_out, instr_valid} !== {10'd2, 1'b0}) begin
      bad++; $display("FAIL held_redirect_bubble: got pc=%0d v=%b want pc=2 v=0", pc_out, instr_valid);
    end
    tick();
    total++;
    if ({pc_out, instr_valid, instr_out} !== {10'd40, 1'b1, ram[40]}) begin
      bad++; $display("FAIL held_redirect_target: got pc=%0d v=%b want pc=40 v=1", pc_out, instr_valid);
    end
    held_pc = m_pc;
    halt_req = 1; redirect_valid = 1; redirect_addr = 2; tick(); halt_req = 0; redirect_valid = 0;
    total++;
    if ({busy, instr_valid, mem_address} !== {1'b0, 1'b0, held_pc}) begin
      bad++; $display("FAIL halt_beats_redirect: got busy=%b v=%b addr=%0d want busy=0 v=0 addr=%0d", busy, instr_valid, mem_address, held_pc);
    end
  endtask

  task automatic test_fault();
    begin_prog(2); tick();
    redirect_valid = 1; redirect_addr = 81; tick(); redirect_valid = 0;
    total++;
    if ({fault, busy, instr_valid} !== 3'b100) begin
      bad++; $display("FAIL bad_redirect: got fault=%b busy=%b v=%b want 1 0 0", fault, busy, instr_valid);
    end
    prog_sel = 1; start = 1; tick(); start = 0;
    total++;
    if ({fault, busy, mem_address} !== {1'b0, 1'b1, 10'd10}) begin
      bad++; $display("FAIL fault_clear: got fault=%b busy=%b addr=%0d want 0 1 10", fault, busy, mem_address);
    end
    redirect_valid = 1; redirect_addr = 78; tick(); redirect_valid = 0;
    for (int i = 0; i < 10 && m_state == 1; i++) begin
      tick();
      total++;
      if ({instr_out, pc_out, instr_valid, busy, fault} !== {m_instr, m_pcout, m_valid, m_state == 1, m_fault}) begin
        bad++; $display("FAIL end_of_range: got pc=%0d v=%b busy=%b fault=%b want pc=%0d v=%b busy=%b fault=%b", pc_out, instr_valid, busy, fault, m_pcout, m_valid, m_state == 1, m_fault);
      end
    end
    total++;
    if ({pc_out, fault, busy} !== {10'd80, 1'b1, 1'b0}) begin
      bad++; $display("FAIL last_addr_fault: got pc=%0d fault=%b busy=%b want 80 1 0", pc_out, fault, busy);
    end
  endtask

  task automatic test_debug();
    halt_req = 1; tick(); halt_req = 0;
    dbg_req = 1; dbg_addr = 21; #1;
    total++;
    if ({dbg_gnt, dbg_rdata, mem_address} !== {1'b1, ram[21], 10'd21}) begin
      bad++; $display("FAIL dbg_idle: got gnt=%b data=%h addr=%0d want 1 %h 21", dbg_gnt, dbg_rdata, mem_address, ram[21]);
    end
    prog_sel = 2; start = 1; #1;
    total++;
    if ({dbg_gnt, dbg_rdata} !== {1'b0, 32'd0}) begin
      bad++; $display("FAIL dbg_vs_start: got gnt=%b data=%h want 0 0", dbg_gnt, dbg_rdata);
    end
    tick(); start = 0; dbg_addr = 3;
    total++;
    if ({dbg_gnt, dbg_rdata, mem_address} !== {1'b0, 32'd0, 10'd21}) begin
      bad++; $display("FAIL dbg_in_run: got gnt=%b data=%h addr=%0d want 0 0 21", dbg_gnt, dbg_rdata, mem_address);
    end
    tick(); dbg_req = 0;
    total++;
    if ({pc_out, instr_out, instr_valid} !== {10'd21, ram[21], 1'b1}) begin
      bad++; $display("FAIL dbg_fetch_intact: got pc=%0d v=%b want pc=21 v=1", pc_out, instr_valid);
    end
  endtask

  task automatic test_random();
    logic exp_gnt;
    for (int i = 0; i < 600; i++) begin
      start          = ($urandom_range(0, 15) == 0);
      prog_sel       = 2'($urandom_range(0, 3));
      stall          = ($urandom_range(0, 5) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_addr  = 10'($urandom_range(0, 84));
      halt_req       = ($urandom_range(0, 40) == 0);
      dbg_req        = ($urandom_range(0, 2) == 0);
      dbg_addr       = 10'($urandom_range(0, 1023));
      #1;
      exp_gnt = dbg_req && (m_state != 1) && !start;
      total++;
      if ({dbg_gnt, dbg_rdata, mem_address} !== {exp_gnt, exp_gnt ? ram[dbg_addr] : 32'd0, exp_gnt ? dbg_addr : m_pc}) begin
        bad++; $display("FAIL rand_port_%0d: got gnt=%b addr=%0d data=%h want gnt=%b addr=%0d", i, dbg_gnt, mem_address, dbg_rdata, exp_gnt, exp_gnt ? dbg_addr : m_pc);
      end
      tick();
      total++;
      if ({instr_out, pc_out, instr_valid, busy, fault} !== {m_instr, m_pcout, m_valid, m_state == 1, m_fault}) begin
        bad++; $display("FAIL rand_out_%0d: got instr=%h pc=%0d v=%b busy=%b fault=%b want instr=%h pc=%0d v=%b busy=%b fault=%b", i, instr_out, pc_out, instr_valid, busy, fault, m_instr, m_pcout, m_valid, m_state == 1, m_fault);
      end
    end
    {start, stall, redirect_valid, halt_req, dbg_req} = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = $urandom;
    test_reset();
    test_sequence();
    test_stall();
    test_stall_redirect();
    test_fault();
    test_debug();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
